lsu: RTL
========

# lsu

Load/store unit for the RV32I execute/memory boundary. Consumes the effective address produced by the ALU (`ALU_ADD` of rs1 + imm), the store operand and the load/store width code. Runs one request/ready transaction on the data-memory port with byte-lane steering. Returns a sign- or zero-extended load result to writeback, or flags a misaligned or illegal access without touching memory.

## Interface
Parameters:
- none; data and address widths are fixed at 32.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request strobe from execute; honoured only when `busy` is low.
- `isStore` in 1: 1 = store, 0 = load.
- `funct3` in 3: width code (LS_B, LS_H, LS_W, LS_BU, LS_HU).
- `addr` in 32: effective byte address (ALU result).
- `storeData` in 32: rs2 value; low byte or half is used for SB/SH.
- `busy` out 1: transaction in flight; upstream must hold off.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misaligned or illegal access.
- `loadResult` out 32: extended load data; valid from `done` until the next accepted `start`.
- `memReq` out 1: memory request.
- `memWe` out 1: write enable.
- `memAddr` out 32: word address `{addr[31:2],2'b00}`.
- `memWData` out 32: lane-replicated store data.
- `memBe` out 4: byte enables.
- `memReady` in 1: memory accepts the request; read data is valid in the same cycle.
- `memRData` in 32: read word.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, `start`=1:
  - Capture `isStore`, `funct3`, `addr`, `storeData`.
  - If legal, go to REQ; otherwise go to DONE with `err`=1.
- Illegal access:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - `funct3` ∈ {011, 110, 111}.
  - Store with BU/HU.
- REQ:
  - `memReq`=1; `memAddr`/`memWe`/`memWData`/`memBe` are driven from the captured values and held stable until `memReady`.
  - On `memReady`=1: latch the extended load (0 for stores) into `loadResult` and go to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state is REQ if `start` is accepted, else IDLE.
- `busy` = (state==REQ).
- `start` while `busy` is ignored.
- Store lanes, with k = `addr[1:0]`:
  - SB: `memBe`=0001<<k, `memWData`={4{storeData[7:0]}}.
  - SH: `memBe`=0011<<k, `memWData`={2{storeData[15:0]}}.
  - SW: `memBe`=1111, `memWData`=`storeData`.
- Loads:
  - `memBe`=1111, `memWe`=0.
  - Shift `memRData` right by 8·k.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Error completion: `loadResult`=0, no `memReq` issued.
- Outside REQ: `memReq`, `memWe`, `memBe` are 0; `memAddr` and `memWData` are don't-care but driven from the captured registers.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `memReq`, `memWe` all 0; `memBe` 0; `loadResult` 0; captured registers 0.
- Reset asserted mid-REQ: `memReq` drops asynchronously and the transaction is abandoned with no `done`.
- Legal access with zero wait states:
  - `start` sampled at edge 0.
  - `memReq` high during cycle 1.
  - `memReady` sampled at edge 1.
  - `done` high during cycle 2.
  - Latency is 2 cycles from accept to `done`.
- Each wait cycle (`memReady`=0) adds one cycle; there is no timeout.
- Illegal access: `done`+`err` in the cycle after accept (latency 1).
- Back-to-back: `start` accepted in the DONE cycle gives `memReq` on the next cycle, i.e. one request every 2 cycles at zero wait.
- `start` in the same cycle as `rst`: reset wins.

## Structure
- Width codes go in the shared `params.vh` next to the ALU codes: LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101.
- State encoding is a localparam inside the block.
- One combinational sub-module, `lsu_align`:
  - Inputs: `funct3`, `addr[1:0]`, `storeData`, `memRData`.
  - Outputs: `memBe`, `memWData`, extended load value, illegal flag.
- The top block holds the FSM and capture registers.

## Test plan
- LW at 0x100, `memRData`=0xDEADBEEF, `memReady` high immediately -> `memAddr`=0x100, `memBe`=1111, `done` 2 cycles after accept, `loadResult`=0xDEADBEEF, `err`=0.
- LB at 0x103 with `memRData`=0x80112233, then LBU at the same address -> `loadResult`=0xFFFFFF80, then 0x00000080.
- SH at 0x202, `storeData`=0x1234ABCD, `memReady` delayed 3 cycles -> `memAddr`=0x200, `memBe`=1100, `memWData`=0xABCDABCD, `memWe`=1; `memReq` held for 4 cycles; `done` 5 cycles after accept.
- LW at 0x101 -> no `memReq`; `done`=1 and `err`=1 one cycle after accept; `loadResult`=0. Repeat with SB and `funct3`=3'b100 (store with BU) -> same response.
- Back-to-back: SB at 0x0 then LW, issued in the `done` cycle -> second `memReq` one cycle after the first `done`. A `start` pulsed while `busy` is ignored.
- `rst` asserted while in REQ with `memReady`=0 -> `memReq` low immediately, no `done`; a fresh LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - width codes and access legality for the load/store unit
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  // Unsigned widths only exist for loads; unused codes are always illegal.
  function automatic logic ls_illegal(input logic [2:0] funct3, input logic is_store,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (funct3)
      LS_B:    bad = 1'b0;
      LS_BU:   bad = is_store;
      LS_H:    bad = addr_lo[0];
      LS_HU:   bad = is_store | addr_lo[0];
      LS_W:    bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  output logic [31:0] load_data_o,
  output logic        illegal_o
);

  logic [31:0] shifted;

  assign shifted   = mem_rdata_i >> {addr_lo_i, 3'b000};
  assign illegal_o = ls_illegal(funct3_i, is_store_i, addr_lo_i);

  always_comb begin
    mem_be_o    = 4'b1111;
    mem_wdata_o = store_data_i;
    load_data_o = shifted;
    case (funct3_i)
      LS_B: begin
        load_data_o = {{24{shifted[7]}}, shifted[7:0]};
        mem_wdata_o = {4{store_data_i[7:0]}};
        if (is_store_i) mem_be_o = 4'b0001 << addr_lo_i;
      end
      LS_BU: load_data_o = {24'h0, shifted[7:0]};
      LS_H: begin
        load_data_o = {{16{shifted[15]}}, shifted[15:0]};
        mem_wdata_o = {2{store_data_i[15:0]}};
        if (is_store_i) mem_be_o = 4'b0011 << addr_lo_i;
      end
      LS_HU: load_data_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request capture, memory handshake FSM, load writeback
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] loadResult,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBe,
  input  logic        memReady,
  input  logic [31:0] memRData
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [31:0] load_result_q;
  logic        err_q;

  logic        in_req;
  logic        sel_store;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic [31:0] sel_store_data;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        align_illegal;

  assign in_req = (state_q == REQ);

  // One aligner serves both jobs: legality of a request being accepted
  // (live inputs) and lane steering of the request in flight (captured).
  assign sel_store      = in_req ? is_store_q        : isStore;
  assign sel_funct3     = in_req ? funct3_q          : funct3;
  assign sel_addr_lo    = in_req ? addr_q[1:0]       : addr[1:0];
  assign sel_store_data = in_req ? store_data_q      : storeData;

  lsu_align u_align (
    .funct3_i     (sel_funct3),
    .is_store_i   (sel_store),
    .addr_lo_i    (sel_addr_lo),
    .store_data_i (sel_store_data),
    .mem_rdata_i  (memRData),
    .mem_be_o     (align_be),
    .mem_wdata_o  (align_wdata),
    .load_data_o  (align_load),
    .illegal_o    (align_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      is_store_q    <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= 32'h0;
      store_data_q  <= 32'h0;
      load_result_q <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (memReady) begin
            load_result_q <= is_store_q ? 32'h0 : align_load;
            state_q       <= DONE;
          end
        end
        default: begin
          err_q <= 1'b0;
          if (start) begin
            is_store_q    <= isStore;
            funct3_q      <= funct3;
            addr_q        <= addr;
            store_data_q  <= storeData;
            load_result_q <= 32'h0;
            if (align_illegal) begin
              state_q <= DONE;
              err_q   <= 1'b1;
            end else begin
              state_q <= REQ;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy       = in_req;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign loadResult = load_result_q;
  assign memReq     = in_req;
  assign memWe      = in_req & is_store_q;
  assign memBe      = in_req ? align_be : 4'b0000;
  assign memAddr    = {addr_q[31:2], 2'b00};
  assign memWData   = in_req ? align_wdata : store_data_q;

endmodule
